// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared types and constants for the fetch->decode instruction queue.
package inst_queue_pkg;

   typedef logic [31:0] PC;
   typedef logic [31:0] REG_WIDTH;
   typedef logic        bool;

   // One fetch slot; only slot 0's valid_number is meaningful for the whole bundle.
   typedef struct packed {
      REG_WIDTH   inst;
      logic [2:0] valid_number;
   } DECODE_REQUIRE;

   localparam int unsigned IQ_DEPTH  = 16;
   localparam int unsigned IQ_BUNDLE = 4;

   typedef logic [$clog2(IQ_DEPTH)-1:0] IQ_PTR;

   typedef struct packed {
      PC        pc;
      REG_WIDTH inst;
   } IQ_ENTRY;

   // Number of bundle slots actually kept: anything above a full bundle saturates.
   function automatic logic [2:0] iq_clamp_count(input logic [2:0] valid_number);
      return (valid_number > 3'd4) ? 3'd4 : valid_number;
   endfunction

endpackage

// File: rtl/inst_queue_storage.sv
// iq_storage: DEPTH-entry register array, 4 masked write ports from a common
// base index and OUT_WIDTH combinational read ports, all indices modulo DEPTH.
module iq_storage
   import inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH     = IQ_DEPTH,
   parameter int unsigned OUT_WIDTH = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [$clog2(DEPTH)-1:0]          wr_base,
   input  logic [IQ_BUNDLE-1:0]              wr_en,
   input  IQ_ENTRY [IQ_BUNDLE-1:0]           wr_data,
   input  logic [$clog2(DEPTH)-1:0]          rd_base,
   output IQ_ENTRY [OUT_WIDTH-1:0]           rd_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   IQ_ENTRY [DEPTH-1:0] mem_q;
   IQ_ENTRY [DEPTH-1:0] mem_d;

   // Merge enabled write ports into the array; index arithmetic wraps at PTR_W bits.
   always_comb begin
      mem_d = mem_q;
      for (int unsigned i = 0; i < IQ_BUNDLE; i++) begin
         if (wr_en[i]) begin
            mem_d[wr_base + PTR_W'(i)] = wr_data[i];
         end
      end
   end

   // Storage registers, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read the OUT_WIDTH oldest entries starting at the head index.
   always_comb begin
      for (int unsigned k = 0; k < OUT_WIDTH; k++) begin
         rd_data[k] = mem_q[rd_base + PTR_W'(k)];
      end
   end

endmodule

// File: rtl/inst_queue.sv
// inst_queue: circular instruction queue between fetch and decode.
// Takes up to 4 instructions per cycle, offers up to OUT_WIDTH in order.
// Optional INST_QUEUE_BYPASS_EN: an empty queue forwards the incoming bundle
// to decode in the same cycle and stores only what decode did not take.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH     = IQ_DEPTH,
   parameter int unsigned OUT_WIDTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        enq_valid,
   input  PC                           enq_pc,
   input  DECODE_REQUIRE [3:0]         enq_bundle,
   output logic                        enq_ready,
   output logic [OUT_WIDTH-1:0]        deq_valid,
   output REG_WIDTH [OUT_WIDTH-1:0]    deq_inst,
   output PC [OUT_WIDTH-1:0]           deq_pc,
   input  logic                        deq_ready,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]        head_q, head_d;
   logic [PTR_W-1:0]        tail_q, tail_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [2:0]              enq_n;
   logic [2:0]              byp_n;
   logic [2:0]              wr_n;
   logic [3:0]              src;
   logic                    enq_fire;
   logic [CNT_W-1:0]        pop_n;
   logic [IQ_BUNDLE-1:0]    wr_en;
   IQ_ENTRY [IQ_BUNDLE-1:0] wr_data;
   IQ_ENTRY [OUT_WIDTH-1:0] rd_data;
   logic                    unused_vn;

   iq_storage #(
      .DEPTH     (DEPTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_storage (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_base (tail_q),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_base (head_q),
      .rd_data (rd_data)
   );

   // Enqueue acceptance: room for a full bundle judged on the current count only.
   always_comb begin
      enq_n     = iq_clamp_count(enq_bundle[0].valid_number);
      enq_ready = (count_q <= CNT_W'(DEPTH - IQ_BUNDLE));
      enq_fire  = enq_valid && enq_ready && !flush;
      unused_vn = ^{enq_bundle[1].valid_number, enq_bundle[2].valid_number,
                    enq_bundle[3].valid_number};
   end

   // Decode-facing outputs and pop count; bypass overrides them when the queue is empty.
   always_comb begin
      byp_n = '0;
      pop_n = '0;
      if (deq_ready) begin
         pop_n = (count_q < CNT_W'(OUT_WIDTH)) ? count_q : CNT_W'(OUT_WIDTH);
      end
      for (int unsigned k = 0; k < OUT_WIDTH; k++) begin
         deq_valid[k] = (count_q > CNT_W'(k));
         deq_inst[k]  = rd_data[k].inst;
         deq_pc[k]    = rd_data[k].pc;
      end
`ifdef INST_QUEUE_BYPASS_EN
      if (enq_fire && (count_q == '0)) begin
         for (int unsigned k = 0; k < OUT_WIDTH; k++) begin
            deq_valid[k] = (enq_n > 3'(k));
            deq_inst[k]  = enq_bundle[k].inst;
            deq_pc[k]    = enq_pc + PC'(4 * k);
         end
         if (deq_ready) begin
            byp_n = (enq_n < 3'(OUT_WIDTH)) ? enq_n : 3'(OUT_WIDTH);
         end
      end
`endif
   end

   // Write the kept slots not consumed by bypass, packed down to start at tail.
   always_comb begin
      wr_en   = '0;
      wr_data = '0;
      src     = '0;
      for (int unsigned j = 0; j < IQ_BUNDLE; j++) begin
         src = 4'(j) + {1'b0, byp_n};
         if (enq_fire && (src < {1'b0, enq_n})) begin
            wr_en[j]        = 1'b1;
            wr_data[j].inst = enq_bundle[src[1:0]].inst;
            wr_data[j].pc   = enq_pc + PC'({src, 2'b00});
         end
      end
   end

   // Next pointer and occupancy state; flush wins over enqueue and pop.
   always_comb begin
      wr_n    = enq_fire ? (enq_n - byp_n) : '0;
      head_d  = head_q + PTR_W'(pop_n);
      tail_d  = tail_q + PTR_W'(wr_n);
      count_d = count_q + CNT_W'(wr_n) - pop_n;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;

   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed vector table, multi-cycle corner sequences and a
// reference-model random run for inst_queue (DEPTH=16, OUT_WIDTH=2).
module tb_inst_queue;
   import inst_queue_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               flush;
   logic               enq_valid;
   PC                  enq_pc;
   DECODE_REQUIRE [3:0] enq_bundle;
   logic               enq_ready;
   logic [1:0]         deq_valid;
   REG_WIDTH [1:0]     deq_inst;
   PC [1:0]            deq_pc;
   logic               deq_ready;
   logic [4:0]         count;

   int unsigned errors = 0;
   int unsigned checks = 0;

   inst_queue #(.DEPTH(16), .OUT_WIDTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .enq_valid  (enq_valid),
      .enq_pc     (enq_pc),
      .enq_bundle (enq_bundle),
      .enq_ready  (enq_ready),
      .deq_valid  (deq_valid),
      .deq_inst   (deq_inst),
      .deq_pc     (deq_pc),
      .deq_ready  (deq_ready),
      .count      (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          fl;
      bit          ev;
      logic [31:0] pc;
      logic [2:0]  vn;
      logic [31:0] ib;
      bit          dr;
      int unsigned cnt;
      logic [1:0]  dv;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic [31:0] i0;
      bit          rdy;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   vec_t vt[23];
   ent_t mq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit fl, input bit ev, input logic [31:0] pc,
                        input logic [2:0] vn, input logic [31:0] ib, input bit dr);
      flush     = fl;
      enq_valid = ev;
      enq_pc    = pc;
      deq_ready = dr;
      for (int i = 0; i < 4; i++) begin
         enq_bundle[i].inst         = ib + 32'(i);
         enq_bundle[i].valid_number = vn;
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0);
   endtask

   initial begin
      // fl ev pc vn ib dr | count dv pc0 pc1 inst0 enq_ready (state after the edge)
      vt[0]  = '{0, 1, 32'hBFC00000, 3'd4, 32'h100, 0, 4,  2'b11, 32'hBFC00000, 32'hBFC00004, 32'h100, 1};
      vt[1]  = '{0, 0, 32'h0,        3'd0, 32'h0,   1, 2,  2'b11, 32'hBFC00008, 32'hBFC0000C, 32'h102, 1};
      vt[2]  = '{0, 1, 32'h1000,     3'd2, 32'h200, 0, 4,  2'b11, 32'hBFC00008, 32'hBFC0000C, 32'h102, 1};
      vt[3]  = '{0, 0, 32'h0,        3'd0, 32'h0,   1, 2,  2'b11, 32'h1000,     32'h1004,     32'h200, 1};
      vt[4]  = '{0, 0, 32'h0,        3'd0, 32'h0,   1, 0,  2'b00, 32'h0,        32'h0,        32'h0,   1};
      vt[5]  = '{0, 0, 32'h0,        3'd0, 32'h0,   1, 0,  2'b00, 32'h0,        32'h0,        32'h0,   1};
      vt[6]  = '{0, 1, 32'h2000,     3'd7, 32'h300, 0, 4,  2'b11, 32'h2000,     32'h2004,     32'h300, 1};
      vt[7]  = '{0, 1, 32'h3000,     3'd0, 32'h3FF, 0, 4,  2'b11, 32'h2000,     32'h2004,     32'h300, 1};
      vt[8]  = '{0, 1, 32'h4000,     3'd4, 32'h400, 1, 6,  2'b11, 32'h2008,     32'h200C,     32'h302, 1};
      vt[9]  = '{0, 1, 32'h5000,     3'd4, 32'h500, 0, 10, 2'b11, 32'h2008,     32'h200C,     32'h302, 1};
      vt[10] = '{0, 1, 32'h6000,     3'd3, 32'h600, 0, 13, 2'b11, 32'h2008,     32'h200C,     32'h302, 0};
      vt[11] = '{0, 1, 32'hA000,     3'd4, 32'hA00, 0, 13, 2'b11, 32'h2008,     32'h200C,     32'h302, 0};
      vt[12] = '{0, 1, 32'hA000,     3'd4, 32'hA00, 1, 11, 2'b11, 32'h4000,     32'h4004,     32'h400, 1};
      vt[13] = '{0, 1, 32'h7000,     3'd1, 32'h700, 0, 12, 2'b11, 32'h4000,     32'h4004,     32'h400, 1};
      vt[14] = '{0, 1, 32'h8000,     3'd4, 32'h800, 0, 16, 2'b11, 32'h4000,     32'h4004,     32'h400, 0};
      vt[15] = '{0, 1, 32'hA000,     3'd4, 32'hA00, 1, 14, 2'b11, 32'h4008,     32'h400C,     32'h402, 0};
      vt[16] = '{0, 0, 32'h0,        3'd0, 32'h0,   1, 12, 2'b11, 32'h5000,     32'h5004,     32'h500, 1};
      vt[17] = '{0, 0, 32'h0,        3'd0, 32'h0,   1, 10, 2'b11, 32'h5008,     32'h500C,     32'h502, 1};
      vt[18] = '{0, 0, 32'h0,        3'd0, 32'h0,   1, 8,  2'b11, 32'h6000,     32'h6004,     32'h600, 1};
      vt[19] = '{0, 0, 32'h0,        3'd0, 32'h0,   1, 6,  2'b11, 32'h6008,     32'h7000,     32'h602, 1};
      vt[20] = '{1, 1, 32'hB000,     3'd4, 32'hB00, 1, 0,  2'b00, 32'h0,        32'h0,        32'h0,   1};
      vt[21] = '{0, 0, 32'h0,        3'd0, 32'h0,   0, 0,  2'b00, 32'h0,        32'h0,        32'h0,   1};
      vt[22] = '{0, 1, 32'h9000,     3'd1, 32'h900, 0, 1,  2'b01, 32'h9000,     32'h0,        32'h900, 1};

      // Reset state
      rst_n = 1'b0;
      idle();
      #12;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_deq_valid", 32'(deq_valid), 32'd0);
      chk("reset_enq_ready", 32'(enq_ready), 32'd1);
      chk("reset_deq_pc0", deq_pc[0], 32'h0);
      chk("reset_deq_inst0", deq_inst[0], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         drive(vt[i].fl, vt[i].ev, vt[i].pc, vt[i].vn, vt[i].ib, vt[i].dr);
         @(posedge clk);
         #1;
         idle();
         #1;
         chk($sformatf("v%0d_count", i), 32'(count), vt[i].cnt);
         chk($sformatf("v%0d_deq_valid", i), 32'(deq_valid), 32'(vt[i].dv));
         chk($sformatf("v%0d_enq_ready", i), 32'(enq_ready), 32'(vt[i].rdy));
         if (vt[i].dv[0]) begin
            chk($sformatf("v%0d_pc0", i), deq_pc[0], vt[i].pc0);
            chk($sformatf("v%0d_inst0", i), deq_inst[0], vt[i].i0);
         end
         if (vt[i].dv[1]) begin
            chk($sformatf("v%0d_pc1", i), deq_pc[1], vt[i].pc1);
         end
      end

      // Empty the queue, then enqueue 3 with decode ready
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b1, 32'hC000, 3'd3, 32'hC00, 1'b1);
      #1;
`ifdef INST_QUEUE_BYPASS_EN
      chk("byp_same_dv", 32'(deq_valid), 32'h3);
      chk("byp_same_pc0", deq_pc[0], 32'hC000);
      chk("byp_same_pc1", deq_pc[1], 32'hC004);
      chk("byp_same_inst1", deq_inst[1], 32'hC01);
      chk("byp_same_count", 32'(count), 32'd0);
      @(posedge clk);
      #1;
      idle();
      #1;
      chk("byp_next_count", 32'(count), 32'd1);
      chk("byp_next_dv", 32'(deq_valid), 32'h1);
      chk("byp_next_pc0", deq_pc[0], 32'hC008);
      chk("byp_next_inst0", deq_inst[0], 32'hC02);
`else
      chk("lat_same_dv", 32'(deq_valid), 32'h0);
      @(posedge clk);
      #1;
      idle();
      #1;
      chk("lat_next_count", 32'(count), 32'd3);
      chk("lat_next_dv", 32'(deq_valid), 32'h3);
      chk("lat_next_pc0", deq_pc[0], 32'hC000);
      chk("lat_next_pc1", deq_pc[1], 32'hC004);
`endif

      // Flush, then random traffic against a queue model
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0);
      mq.delete();
      for (int c = 0; c < 10000; c++) begin
         bit          fl, ev, dr, fire, byp;
         logic [2:0]  vn;
         logic [31:0] pc, ib;
         int unsigned msz, nn;
         @(negedge clk);
         fl = ($urandom_range(0, 49) == 0);
         ev = ($urandom_range(0, 2) != 0);
         dr = ($urandom_range(0, 1) != 0);
         vn = 3'($urandom_range(0, 7));
         pc = $urandom & 32'hFFFF_FFFC;
         ib = $urandom;
         drive(fl, ev, pc, vn, ib, dr);
         #1;
         msz  = mq.size();
         chk("rnd_enq_ready", 32'(enq_ready), 32'(msz <= 12));
         chk("rnd_count", 32'(count), msz);
         fire = ev && (msz <= 12) && !fl;
         nn   = (vn > 3'd4) ? 4 : int'(vn);
         byp  = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
         if (fire && (msz == 0)) begin
            byp = 1'b1;
            for (int i = 0; i < nn; i++) mq.push_back('{pc + 32'(4 * i), ib + 32'(i)});
         end
`endif
         for (int k = 0; k < 2; k++) begin
            chk("rnd_deq_valid", 32'(deq_valid[k]), 32'(mq.size() > k));
            if (mq.size() > k) begin
               chk("rnd_deq_pc", deq_pc[k], mq[k].pc);
               chk("rnd_deq_inst", deq_inst[k], mq[k].inst);
            end
         end
         if (fl) begin
            mq.delete();
         end else begin
            if (dr) begin
               for (int k = 0; k < 2; k++) begin
                  if (mq.size() > 0) void'(mq.pop_front());
               end
            end
            if (fire && !byp) begin
               for (int i = 0; i < nn; i++) mq.push_back('{pc + 32'(4 * i), ib + 32'(i)});
            end
         end
      end

      @(negedge clk);
      idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
